// File: rtl/calc_sequencer.sv
// Key-driven sequencer for the BCD adder path: turns decoded keypad events into
// one-cycle strobes for the entry/save/sum stages and selects the display source.
module calc_sequencer #(
    parameter int MAX_DIGITS  = 4,
    parameter int SUM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       sum_done,
    output logic       key_ack,
    output logic       push,
    output logic [3:0] entrada,
    output logic       clr_entry,
    output logic       clr_all,
    output logic       guardar,
    output logic       suma,
    output logic       disp_sel,
    output logic [2:0] digit_cnt,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_ENTRY_A,
        S_ENTRY_B,
        S_WAIT_SUM,
        S_SHOW,
        S_PEND_PUSH
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
    localparam logic [7:0] TMO_LD  = 8'(SUM_TIMEOUT);

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_EQ  = 4'hB;
    localparam logic [3:0] K_CLR = 4'hC;

    state_t     state_q, state_d;
    logic [2:0] digit_cnt_q, digit_cnt_d;
    logic [7:0] tmr_q, tmr_d;
    logic [3:0] latch_q, latch_d;
    logic [3:0] entrada_q, entrada_d;
    logic       err_q, err_d;
    logic       key_ack_q, key_ack_d;
    logic       push_q, push_d;
    logic       clr_entry_q, clr_entry_d;
    logic       clr_all_q, clr_all_d;
    logic       guardar_q, guardar_d;
    logic       suma_q, suma_d;
    logic       disp_sel_q, disp_sel_d;
    logic       busy_q, busy_d;

    logic accept;
    logic is_digit;

    assign accept   = key_valid && !busy_q;
    assign is_digit = (key_code <= 4'd9);

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        tmr_d       = tmr_q;
        latch_d     = latch_q;
        entrada_d   = entrada_q;
        err_d       = err_q;
        key_ack_d   = 1'b0;
        push_d      = 1'b0;
        clr_entry_d = 1'b0;
        clr_all_d   = 1'b0;
        guardar_d   = 1'b0;
        suma_d      = 1'b0;

        if (accept) begin
            key_ack_d = 1'b1;
            err_d     = 1'b0;
        end

        case (state_q)
            S_ENTRY_A, S_ENTRY_B: begin
                if (accept) begin
                    if (is_digit) begin
                        if (digit_cnt_q < MAX_CNT) begin
                            push_d      = 1'b1;
                            entrada_d   = key_code;
                            digit_cnt_d = digit_cnt_q + 3'd1;
                        end
                    end else if (state_q == S_ENTRY_A) begin
                        if (key_code == K_ADD && digit_cnt_q != 3'd0) begin
                            guardar_d   = 1'b1;
                            clr_entry_d = 1'b1;
                            digit_cnt_d = 3'd0;
                            state_d     = S_ENTRY_B;
                        end else if (key_code == K_CLR) begin
                            clr_entry_d = 1'b1;
                            digit_cnt_d = 3'd0;
                        end
                    end else begin
                        if (key_code == K_EQ && digit_cnt_q != 3'd0) begin
                            suma_d  = 1'b1;
                            tmr_d   = TMO_LD;
                            state_d = S_WAIT_SUM;
                        end else if (key_code == K_CLR) begin
                            clr_all_d   = 1'b1;
                            digit_cnt_d = 3'd0;
                            state_d     = S_ENTRY_A;
                        end
                    end
                end
            end
            S_WAIT_SUM: begin
                // The suma cycle still holds the freshly loaded count, so a
                // sum_done there is too early to belong to this addition.
                if (sum_done && tmr_q != TMO_LD) begin
                    state_d = S_SHOW;
                end else if (tmr_q <= 8'd1) begin
                    tmr_d       = 8'd0;
                    err_d       = 1'b1;
                    clr_all_d   = 1'b1;
                    digit_cnt_d = 3'd0;
                    state_d     = S_ENTRY_A;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            S_SHOW: begin
                if (accept) begin
                    if (is_digit) begin
                        clr_all_d   = 1'b1;
                        latch_d     = key_code;
                        digit_cnt_d = 3'd0;
                        state_d     = S_PEND_PUSH;
                    end else if (key_code == K_CLR) begin
                        clr_all_d   = 1'b1;
                        digit_cnt_d = 3'd0;
                        state_d     = S_ENTRY_A;
                    end
                end
            end
            S_PEND_PUSH: begin
                push_d      = 1'b1;
                entrada_d   = latch_q;
                digit_cnt_d = 3'd1;
                state_d     = S_ENTRY_A;
            end
            default: begin
                state_d     = S_ENTRY_A;
                digit_cnt_d = 3'd0;
            end
        endcase

        disp_sel_d = (state_d == S_SHOW);
        busy_d     = (state_d == S_WAIT_SUM) || (state_d == S_PEND_PUSH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_ENTRY_A;
            digit_cnt_q <= 3'd0;
            tmr_q       <= 8'd0;
            latch_q     <= 4'd0;
            entrada_q   <= 4'd0;
            err_q       <= 1'b0;
            key_ack_q   <= 1'b0;
            push_q      <= 1'b0;
            clr_entry_q <= 1'b0;
            clr_all_q   <= 1'b0;
            guardar_q   <= 1'b0;
            suma_q      <= 1'b0;
            disp_sel_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            tmr_q       <= tmr_d;
            latch_q     <= latch_d;
            entrada_q   <= entrada_d;
            err_q       <= err_d;
            key_ack_q   <= key_ack_d;
            push_q      <= push_d;
            clr_entry_q <= clr_entry_d;
            clr_all_q   <= clr_all_d;
            guardar_q   <= guardar_d;
            suma_q      <= suma_d;
            disp_sel_q  <= disp_sel_d;
            busy_q      <= busy_d;
        end
    end

    assign key_ack   = key_ack_q;
    assign push      = push_q;
    assign entrada   = entrada_q;
    assign clr_entry = clr_entry_q;
    assign clr_all   = clr_all_q;
    assign guardar   = guardar_q;
    assign suma      = suma_q;
    assign disp_sel  = disp_sel_q;
    assign digit_cnt = digit_cnt_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: entry, add, busy drop, timeout, show and
// reset sequences, checking the full output vector every step.
module tb_calc_sequencer;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_code;
    logic       sum_done;
    logic       key_ack;
    logic       push;
    logic [3:0] entrada;
    logic       clr_entry;
    logic       clr_all;
    logic       guardar;
    logic       suma;
    logic       disp_sel;
    logic [2:0] digit_cnt;
    logic       busy;
    logic       err;

    int tests;
    int failed;

    calc_sequencer #(.MAX_DIGITS(4), .SUM_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .sum_done  (sum_done),
        .key_ack   (key_ack),
        .push      (push),
        .entrada   (entrada),
        .clr_entry (clr_entry),
        .clr_all   (clr_all),
        .guardar   (guardar),
        .suma      (suma),
        .disp_sel  (disp_sel),
        .digit_cnt (digit_cnt),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] outs();
        return {key_ack, push, entrada, clr_entry, clr_all, guardar, suma,
                disp_sel, digit_cnt, busy, err};
    endfunction

    // Order: ack, push, entrada, clr_entry, clr_all, guardar, suma, disp_sel, digit_cnt, busy, err
    function automatic logic [15:0] ex(input logic a, input logic p, input logic [3:0] e,
                                       input logic ce, input logic ca, input logic g,
                                       input logic s, input logic ds, input logic [2:0] c,
                                       input logic b, input logic er);
        return {a, p, e, ce, ca, g, s, ds, c, b, er};
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = outs();
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
        end
    endtask

    // Presents a key for one cycle; returns at the negedge of the response cycle.
    task automatic key(input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        sum_done  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", 16'h0000);
        rst = 1'b0;

        for (int d = 1; d <= 4; d++) begin
            key(4'(d));
            chk("entry_push", ex(1, 1, 4'(d), 0, 0, 0, 0, 0, 3'(d), 0, 0));
        end
        key(4'd5);
        chk("entry_drop", ex(1, 0, 4'd4, 0, 0, 0, 0, 0, 3'd4, 0, 0));
        @(negedge clk);
        chk("entry_idle", ex(0, 0, 4'd4, 0, 0, 0, 0, 0, 3'd4, 0, 0));
        key(4'hC);
        chk("clr_a", ex(1, 0, 4'd4, 1, 0, 0, 0, 0, 3'd0, 0, 0));
        key(4'hA);
        chk("a_cnt0", ex(1, 0, 4'd4, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        key(4'hB);
        chk("b_in_a", ex(1, 0, 4'd4, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        key(4'hE);
        chk("code_e", ex(1, 0, 4'd4, 0, 0, 0, 0, 0, 3'd0, 0, 0));

        key(4'd7);
        chk("push7", ex(1, 1, 4'd7, 0, 0, 0, 0, 0, 3'd1, 0, 0));
        key(4'hA);
        chk("guardar", ex(1, 0, 4'd7, 1, 0, 1, 0, 0, 3'd0, 0, 0));
        key(4'hA);
        chk("a_in_b", ex(1, 0, 4'd7, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        key(4'hB);
        chk("b_cnt0", ex(1, 0, 4'd7, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        key(4'd8);
        chk("push8", ex(1, 1, 4'd8, 0, 0, 0, 0, 0, 3'd1, 0, 0));
        key(4'hB);
        chk("suma", ex(1, 0, 4'd8, 0, 0, 0, 1, 0, 3'd1, 1, 0));
        key_valid = 1'b1;
        key_code  = 4'd5;
        @(negedge clk);
        key_valid = 1'b0;
        chk("busy_drop", ex(0, 0, 4'd8, 0, 0, 0, 0, 0, 3'd1, 1, 0));
        @(negedge clk);
        chk("wait_sum", ex(0, 0, 4'd8, 0, 0, 0, 0, 0, 3'd1, 1, 0));
        sum_done = 1'b1;
        @(negedge clk);
        sum_done = 1'b0;
        chk("show", ex(0, 0, 4'd8, 0, 0, 0, 0, 1, 3'd1, 0, 0));

        key(4'hA);
        chk("a_in_show", ex(1, 0, 4'd8, 0, 0, 0, 0, 1, 3'd1, 0, 0));
        key(4'd9);
        chk("show_digit_clr", ex(1, 0, 4'd8, 0, 1, 0, 0, 0, 3'd0, 1, 0));
        @(negedge clk);
        chk("pend_push", ex(0, 1, 4'd9, 0, 0, 0, 0, 0, 3'd1, 0, 0));

        key(4'hA);
        chk("guardar2", ex(1, 0, 4'd9, 1, 0, 1, 0, 0, 3'd0, 0, 0));
        key(4'd3);
        chk("push3", ex(1, 1, 4'd3, 0, 0, 0, 0, 0, 3'd1, 0, 0));
        key(4'hB);
        chk("suma2", ex(1, 0, 4'd3, 0, 0, 0, 1, 0, 3'd1, 1, 0));
        sum_done = 1'b1;
        @(negedge clk);
        sum_done = 1'b0;
        chk("early_done_ignored", ex(0, 0, 4'd3, 0, 0, 0, 0, 0, 3'd1, 1, 0));
        repeat (14) @(negedge clk);
        chk("tmo_wait", ex(0, 0, 4'd3, 0, 0, 0, 0, 0, 3'd1, 1, 0));
        @(negedge clk);
        chk("timeout", ex(0, 0, 4'd3, 0, 1, 0, 0, 0, 3'd0, 0, 1));
        @(negedge clk);
        chk("err_sticky", ex(0, 0, 4'd3, 0, 0, 0, 0, 0, 3'd0, 0, 1));
        key(4'd2);
        chk("err_clear", ex(1, 1, 4'd2, 0, 0, 0, 0, 0, 3'd1, 0, 0));

        key(4'hA);
        chk("guardar3", ex(1, 0, 4'd2, 1, 0, 1, 0, 0, 3'd0, 0, 0));
        key(4'd4);
        chk("push4", ex(1, 1, 4'd4, 0, 0, 0, 0, 0, 3'd1, 0, 0));
        key(4'hB);
        chk("suma3", ex(1, 0, 4'd4, 0, 0, 0, 1, 0, 3'd1, 1, 0));
        @(negedge clk);
        rst = 1'b1;
        chk("pre_rst_wait", ex(0, 0, 4'd4, 0, 0, 0, 0, 0, 3'd1, 1, 0));
        @(negedge clk);
        chk("rst_mid", 16'h0000);
        rst      = 1'b0;
        sum_done = 1'b1;
        @(negedge clk);
        sum_done = 1'b0;
        chk("done_after_rst", 16'h0000);
        key(4'hB);
        chk("b_after_rst", ex(1, 0, 4'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0));

        key(4'd1);
        chk("push1", ex(1, 1, 4'd1, 0, 0, 0, 0, 0, 3'd1, 0, 0));
        key(4'hA);
        chk("guardar4", ex(1, 0, 4'd1, 1, 0, 1, 0, 0, 3'd0, 0, 0));
        key(4'd6);
        chk("push6", ex(1, 1, 4'd6, 0, 0, 0, 0, 0, 3'd1, 0, 0));
        key(4'hB);
        chk("suma4", ex(1, 0, 4'd6, 0, 0, 0, 1, 0, 3'd1, 1, 0));
        repeat (15) @(negedge clk);
        chk("last_wait", ex(0, 0, 4'd6, 0, 0, 0, 0, 0, 3'd1, 1, 0));
        sum_done = 1'b1;
        @(negedge clk);
        sum_done = 1'b0;
        chk("done_wins", ex(0, 0, 4'd6, 0, 0, 0, 0, 1, 3'd1, 0, 0));
        key(4'hC);
        chk("show_clr", ex(1, 0, 4'd6, 0, 1, 0, 0, 0, 3'd0, 0, 0));
        @(negedge clk);
        chk("final_idle", ex(0, 0, 4'd6, 0, 0, 0, 0, 0, 3'd0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
